// File: rtl/led_tape_pkg.sv
// Shared definitions for the LED tape pixel sources: colour word layout,
// colour builders and the peak-dot state encoding.
package led_tape_pkg;

  localparam int RGB_W = 24;

  // Field offsets inside the 24-bit colour word (WS2812 wire order G,R,B)
  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  localparam logic [RGB_W-1:0] COL_OFF = '0;

  typedef enum logic [1:0] {
    PEAK_IDLE = 2'd0,
    PEAK_HOLD = 2'd1,
    PEAK_FALL = 2'd2
  } peak_state_e;

  function automatic logic [RGB_W-1:0] pack_rgb(input logic [7:0] g,
                                                input logic [7:0] r,
                                                input logic [7:0] b);
    logic [RGB_W-1:0] w;
    w = '0;
    w[G_LSB +: 8] = g;
    w[R_LSB +: 8] = r;
    w[B_LSB +: 8] = b;
    return w;
  endfunction

  // Colours for a given channel intensity
  function automatic logic [RGB_W-1:0] col_green(input logic [7:0] bright);
    return pack_rgb(bright, 8'h00, 8'h00);
  endfunction

  function automatic logic [RGB_W-1:0] col_yellow(input logic [7:0] bright);
    return pack_rgb(bright, bright, 8'h00);
  endfunction

  function automatic logic [RGB_W-1:0] col_red(input logic [7:0] bright);
    return pack_rgb(8'h00, bright, 8'h00);
  endfunction

  function automatic logic [RGB_W-1:0] col_white(input logic [7:0] bright);
    return pack_rgb(bright, bright, bright);
  endfunction

endpackage

// File: rtl/led_vu_pixel_source_peak.sv
// vu_peak_tracker: turns the per-frame maximum level into a bar length and
// runs the falling peak-hold dot. Everything advances only on frame edges,
// so both outputs stay constant while the tape is being painted.
module vu_peak_tracker
  import led_tape_pkg::*;
#(
  parameter int NUM_LEDS         = 160,
  parameter int PEAK_HOLD_FRAMES = 30,
  parameter int DECAY_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_edge,
  input  logic [7:0]  max_level,
  output logic [15:0] bar_len,
  output logic [15:0] peak_pos
);

  localparam int HW = (PEAK_HOLD_FRAMES < 1) ? 1 : $clog2(PEAK_HOLD_FRAMES + 1);
  localparam int DW = (DECAY_FRAMES < 2) ? 1 : $clog2(DECAY_FRAMES + 1);
  localparam logic [23:0]   NUM_LEDS_24 = 24'(NUM_LEDS);
  localparam logic [HW-1:0] HOLD_LOAD   = HW'(PEAK_HOLD_FRAMES);
  localparam logic [DW-1:0] DECAY_LAST  = DW'(DECAY_FRAMES - 1);

  logic [23:0]   prod_reg;
  logic [23:0]   prod_next;
  logic          stg1_vld_reg;   // prod_reg freshly loaded
  logic          stg2_vld_reg;   // bar_len_reg freshly loaded
  logic [15:0]   bar_len_reg;
  logic [15:0]   peak_pos_reg;
  logic [15:0]   peak_pos_next;
  logic [HW-1:0] hold_cnt_reg;
  logic [HW-1:0] hold_cnt_next;
  logic [DW-1:0] decay_cnt_reg;
  logic [DW-1:0] decay_cnt_next;
  peak_state_e   state_reg;
  peak_state_e   state_next;

  // Scale 0..255 onto 0..NUM_LEDS-1 with a multiply and a byte shift
  assign prod_next = 24'(max_level) * NUM_LEDS_24;

  // Frame-edge pipeline: product, then bar length, then peak update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_reg     <= '0;
      stg1_vld_reg <= 1'b0;
      stg2_vld_reg <= 1'b0;
      bar_len_reg  <= '0;
    end else begin
      stg1_vld_reg <= frame_edge;
      stg2_vld_reg <= stg1_vld_reg;
      if (frame_edge) begin
        prod_reg <= prod_next;
      end
      if (stg1_vld_reg) begin
        bar_len_reg <= prod_reg[23:8];
      end
    end
  end

  // Peak FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= PEAK_IDLE;
      peak_pos_reg  <= '0;
      hold_cnt_reg  <= '0;
      decay_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      peak_pos_reg  <= peak_pos_next;
      hold_cnt_reg  <= hold_cnt_next;
      decay_cnt_reg <= decay_cnt_next;
    end
  end

  // Peak FSM next state: a bar reaching the dot always re-arms the hold
  always_comb begin
    state_next     = state_reg;
    peak_pos_next  = peak_pos_reg;
    hold_cnt_next  = hold_cnt_reg;
    decay_cnt_next = decay_cnt_reg;
    if (stg2_vld_reg) begin
      if (bar_len_reg >= peak_pos_reg) begin
        peak_pos_next  = bar_len_reg;
        hold_cnt_next  = HOLD_LOAD;
        decay_cnt_next = '0;
        state_next     = PEAK_HOLD;
      end else begin
        // Here peak_pos_reg > bar_len_reg >= 0, so a decrement cannot wrap
        case (state_reg)
          PEAK_HOLD: begin
            if (hold_cnt_reg <= HW'(1)) begin
              hold_cnt_next = '0;
              state_next    = PEAK_FALL;
            end else begin
              hold_cnt_next = hold_cnt_reg - HW'(1);
            end
          end
          PEAK_FALL: begin
            if (decay_cnt_reg == DECAY_LAST) begin
              decay_cnt_next = '0;
              peak_pos_next  = peak_pos_reg - 16'd1;
              if (peak_pos_reg == 16'd1) begin
                state_next = PEAK_IDLE;
              end
            end else begin
              decay_cnt_next = decay_cnt_reg + DW'(1);
            end
          end
          PEAK_IDLE: begin
            peak_pos_next = '0;
          end
          default: begin
            state_next = PEAK_IDLE;
          end
        endcase
      end
    end
  end

  assign bar_len  = bar_len_reg;
  assign peak_pos = peak_pos_reg;

endmodule

// File: rtl/led_vu_pixel_source.sv
// led_vu_pixel_source: VU bar with a peak-hold dot, served pixel by pixel
// to the LED_tape serializer. Level maxima are collected per frame and
// handed to the peak tracker at the rising edge of sync.
module led_vu_pixel_source
  import led_tape_pkg::*;
#(
  parameter int         NUM_LEDS         = 160,
  parameter int         PEAK_HOLD_FRAMES = 30,
  parameter int         DECAY_FRAMES     = 2,
  parameter logic [7:0] BRIGHT           = 8'hFC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  level,
  input  logic        level_valid,
  input  logic        req,
  input  logic [15:0] num,
  input  logic        sync,
  output logic [23:0] rgb
);

  localparam logic [15:0] N_LEDS  = 16'(NUM_LEDS);
  localparam logic [15:0] N_HALF  = 16'(NUM_LEDS / 2);
  localparam logic [15:0] N_3QTR  = 16'((3 * NUM_LEDS) / 4);

  logic        sync_d_reg;
  logic        frame_edge;
  logic [7:0]  max_level_reg;
  logic [15:0] bar_len;
  logic [15:0] peak_pos;
  logic [23:0] rgb_reg;
  logic [23:0] rgb_next;

  assign frame_edge = sync & ~sync_d_reg;

  // Delayed sync for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_d_reg <= 1'b0;
    end else begin
      sync_d_reg <= sync;
    end
  end

  // Running maximum of the frame; a sample on the edge cycle opens the next frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_level_reg <= '0;
    end else if (frame_edge) begin
      max_level_reg <= level_valid ? level : 8'd0;
    end else if (level_valid && (level > max_level_reg)) begin
      max_level_reg <= level;
    end
  end

  vu_peak_tracker #(
    .NUM_LEDS         (NUM_LEDS),
    .PEAK_HOLD_FRAMES (PEAK_HOLD_FRAMES),
    .DECAY_FRAMES     (DECAY_FRAMES)
  ) u_peak (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_edge (frame_edge),
    .max_level  (max_level_reg),
    .bar_len    (bar_len),
    .peak_pos   (peak_pos)
  );

  // Pixel colour for the requested LED: gap, range, bar zones, peak dot
  always_comb begin
    rgb_next = COL_OFF;
    if (sync) begin
      rgb_next = COL_OFF;
    end else if (num >= N_LEDS) begin
      rgb_next = COL_OFF;
    end else if (num < bar_len) begin
      if (num < N_HALF) begin
        rgb_next = col_green(BRIGHT);
      end else if (num < N_3QTR) begin
        rgb_next = col_yellow(BRIGHT);
      end else begin
        rgb_next = col_red(BRIGHT);
      end
    end else if ((peak_pos != 16'd0) && (num == peak_pos)) begin
      rgb_next = col_white(BRIGHT);
    end
  end

  // Colour register: loads on a request, holds otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_reg <= COL_OFF;
    end else if (req) begin
      rgb_reg <= rgb_next;
    end
  end

  assign rgb = rgb_reg;

endmodule

// File: tb/tb_led_vu_pixel_source.sv
// Scoreboard bench for led_vu_pixel_source: stimulus pushes expected colours
// computed from a frame-level model; a negedge monitor pops and compares.
module tb_led_vu_pixel_source;

  localparam int N    = 160;
  localparam int HOLD = 30;
  localparam int DEC  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  level;
  logic        level_valid;
  logic        req;
  logic [15:0] num;
  logic        sync;
  logic [23:0] rgb;

  always #5 clk = ~clk;

  led_vu_pixel_source #(
    .NUM_LEDS         (N),
    .PEAK_HOLD_FRAMES (HOLD),
    .DECAY_FRAMES     (DEC),
    .BRIGHT           (8'hFC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .level       (level),
    .level_valid (level_valid),
    .req         (req),
    .num         (num),
    .sync        (sync),
    .rgb         (rgb)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: rgb=%06h required %06h", name, act, exp);
  endtask

  // ---------------- reference model (frame level) ----------------
  int m_max;   // max level seen in the frame being collected
  int m_bar;   // bar length shown in the current frame
  int m_set;   // position the dot was last raised to
  int m_t;     // frames since it was raised
  bit sync_prev;

  // Dot position: hold HOLD frames, then one LED per DEC frames, floor at 0
  function automatic int m_peak();
    int dec;
    dec = (m_t > HOLD) ? (m_t - HOLD) / DEC : 0;
    return (m_set > dec) ? (m_set - dec) : 0;
  endfunction

  task automatic model_reset();
    m_max = 0; m_bar = 0; m_set = 0; m_t = 0; sync_prev = 0;
  endtask

  task automatic model_frame(input bit lv, input int l);
    m_bar = (m_max * N) / 256;
    if (m_bar >= m_peak()) begin
      m_set = m_bar;
      m_t   = 0;
    end else begin
      m_t++;
    end
    m_max = lv ? l : 0;
  endtask

  function automatic logic [23:0] exp_rgb(input int n, input bit s);
    int pk;
    pk = m_peak();
    if (s) return 24'h000000;
    if (n >= N) return 24'h000000;
    if (n < m_bar) begin
      if (n < N / 2) return 24'hFC0000;
      if (n < (3 * N) / 4) return 24'hFCFC00;
      return 24'h00FC00;
    end
    if (pk != 0 && n == pk) return 24'hFCFCFC;
    return 24'h000000;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [23:0] rgb;
    int          n;
  } exp_t;
  exp_t        q[$];
  logic        pend;
  logic [23:0] last_exp = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend <= 1'b0;
    else          pend <= req;
  end

  always @(negedge clk) begin
    if (pend) begin
      if (q.size() == 0) begin
        chk_cnt++;
        $display("FAIL scoreboard: rgb=%06h with no expected entry", rgb);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("pix n=%0d rgb=%06h exp=%06h", e.n, rgb, e.rgb);
        check($sformatf("pix_n%0d", e.n), rgb, e.rgb);
        last_exp = e.rgb;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit s, input bit r, input int n, input bit lv, input int l);
    @(negedge clk);
    sync        = s;
    req         = r;
    num         = 16'(n);
    level_valid = lv;
    level       = 8'(l);
    if (s && !sync_prev) model_frame(lv, l);
    else if (lv && l > m_max) m_max = l;
    sync_prev = s;
    if (r) q.push_back('{rgb: exp_rgb(n, s), n: n});
  endtask

  task automatic idle(input int k);
    repeat (k) drive(0, 0, 0, 0, 0);
  endtask

  task automatic pix(input int n);
    drive(0, 1, n, 0, 0);
  endtask

  task automatic send_level(input int l);
    drive(0, 0, 0, 1, l);
  endtask

  // Frame gap of 4 sync cycles, with pixel requests during the gap
  task automatic frame(input bit ev, input int el);
    drive(1, 1, int'($urandom_range(0, 170)), ev, el);
    drive(1, 1, 5, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sync = 0; req = 0; num = '0; level_valid = 0; level = '0;
    model_reset();

    // Held in reset, even with a request present
    repeat (2) @(negedge clk);
    req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("in_reset", rgb, 24'h000000);
    end
    req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Dark tape before any frame
    for (int n = 0; n < N; n++) pix(n);
    idle(2);

    // Half-scale level
    send_level(128);
    idle(1);
    frame(0, 0);
    pix(0); pix(79); pix(80); pix(81); pix(10);
    idle(3);
    check("rgb_hold", rgb, last_exp);

    // Full-scale level
    send_level(255);
    frame(0, 0);
    pix(100); pix(130); pix(159); pix(160); pix(0);
    idle(2);

    // Asynchronous reset in the middle of a frame
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset", rgb, 24'h000000);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pix(0); pix(159); pix(80);
    frame(0, 0);
    pix(0); pix(159);

    // Peak hold and decay after a half-scale frame
    send_level(128);
    frame(0, 0);
    for (int f = 0; f < 200; f++) begin
      frame(0, 0);
      pix(0); pix(78); pix(79); pix(80);
      pix(int'($urandom_range(0, 165)));
    end

    // Falling peak overtaken by a new bar; edge-cycle sample carries over
    send_level(96);
    frame(0, 0);
    for (int f = 0; f < 34; f++) frame(0, 0);
    pix(58); pix(59);
    send_level(160);
    frame(1, 50);
    pix(99); pix(100); pix(58);
    frame(0, 0);
    pix(30); pix(31); pix(100);

    // Randomised traffic
    for (int f = 0; f < 50; f++) begin
      for (int c = 0; c < 20; c++) begin
        drive(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 170)),
              ($urandom_range(0, 2) == 0), int'($urandom_range(0, 255)));
      end
      frame(bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      pix(int'($urandom_range(0, 159)));
    end
    idle(3);

    if (q.size() != 0) begin
      chk_cnt++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
